// File: rtl/md5_pkg.sv
// Shared MD5 front-end constants and padder state encoding.
// Used by md5_padder (optional MD5_PADDER_CNT_EN feature lives there).
package md5_pkg;

  localparam int MD5_BLOCK_BITS       = 512;
  localparam logic [7:0] MD5_PAD_BYTE = 8'h80;
  localparam int MD5_LEN_BYTE_OFS     = 56;
  localparam int MD5_MAX_SINGLE_BYTES = 55;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_PAD     = 2'd1;
  localparam logic [1:0] ST_OUT     = 2'd2;
  localparam logic [1:0] ST_DROP    = 2'd3;

  // Message length in bits as the 64-bit MD5 length field.
  function automatic logic [63:0] md5_bitlen(
    input logic [5:0] n
  );
    return {55'd0, n, 3'd0};
  endfunction

endpackage

// File: rtl/md5_padder.sv
// Single-block MD5 padder: byte stream in, padded 512-bit block out.
// Define MD5_PADDER_CNT_EN to add the block_cnt handshake counter.
module md5_padder
  import md5_pkg::*;
#(
  parameter int MAX_BYTES = MD5_MAX_SINGLE_BYTES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [MD5_BLOCK_BITS-1:0] mesg,
  output logic                      mesg_valid,
  input  logic                      mesg_ready,
`ifdef MD5_PADDER_CNT_EN
  output logic [31:0]               block_cnt,
`endif
  output logic                      err
);

  localparam logic [5:0] MAX_C = 6'(MAX_BYTES);

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [63:0] len;
  logic        acc;
  logic        at_max;
  logic        take;

  assign len    = md5_bitlen(cnt);
  assign at_max = (cnt == MAX_C);
  assign acc    = in_valid && in_ready;
  assign take   = mesg_valid && mesg_ready;

  // Ready is a pure function of state, forced low while in reset.
  assign in_ready = !reset &&
                    (state == ST_COLLECT || state == ST_DROP);

  // Main FSM: collect bytes, pad, present block, or drop overlong.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_COLLECT;
      cnt        <= '0;
      mesg       <= '0;
      mesg_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_COLLECT: begin
          if (acc) begin
            if (at_max) begin
              if (in_last) begin
                err   <= 1'b1;
                mesg  <= '0;
                cnt   <= '0;
                state <= ST_COLLECT;
              end else begin
                state <= ST_DROP;
              end
            end else begin
              for (int k = 0; k < MD5_LEN_BYTE_OFS; k++) begin
                if (6'(k) == cnt)
                  mesg[MD5_BLOCK_BITS-1-8*k -: 8] <= in_data;
              end
              cnt <= cnt + 6'd1;
              if (in_last)
                state <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          for (int k = 0; k < MD5_LEN_BYTE_OFS; k++) begin
            if (6'(k) == cnt)
              mesg[MD5_BLOCK_BITS-1-8*k -: 8] <= MD5_PAD_BYTE;
          end
          for (int j = 0; j < 8; j++) begin
            mesg[MD5_BLOCK_BITS-1-8*(MD5_LEN_BYTE_OFS+j) -: 8]
              <= len[8*j +: 8];
          end
          state <= ST_OUT;
        end
        ST_OUT: begin
          if (take) begin
            mesg_valid <= 1'b0;
            mesg       <= '0;
            cnt        <= '0;
            state      <= ST_COLLECT;
          end else begin
            mesg_valid <= 1'b1;
          end
        end
        ST_DROP: begin
          if (acc && in_last) begin
            err   <= 1'b1;
            mesg  <= '0;
            cnt   <= '0;
            state <= ST_COLLECT;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

`ifdef MD5_PADDER_CNT_EN
  // Count delivered blocks; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset)
      block_cnt <= '0;
    else if (take)
      block_cnt <= block_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_md5_padder.sv
// Self-checking bench for md5_padder: table vectors, corner
// sequences and randomized messages against a padding model.
module tb_md5_padder;

  logic         clk;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] mesg;
  logic         mesg_valid;
  logic         mesg_ready;
  logic         err;
`ifdef MD5_PADDER_CNT_EN
  logic [31:0]  block_cnt;
`endif

  md5_padder dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mesg       (mesg),
    .mesg_valid (mesg_valid),
    .mesg_ready (mesg_ready),
`ifdef MD5_PADDER_CNT_EN
    .block_cnt  (block_cnt),
`endif
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int blocks = 0;
  logic [7:0] msg[$];

  typedef struct {
    string        txt;
    int           n;
    logic [7:0]   fill;
    logic [511:0] exp;
  } vec_t;

  vec_t vecs[4];

  always @(negedge clk) if (err) err_seen++;

  task automatic chk(input string name, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Padding model built from byte arithmetic.
  function automatic logic [511:0] model();
    logic [7:0]   blk[64];
    logic [511:0] r;
    int           l;
    longint       bits;
    l = msg.size();
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    for (int i = 0; i < l; i++) blk[i] = msg[i];
    blk[l] = 8'h80;
    bits = longint'(l) * 8;
    for (int j = 0; j < 8; j++) blk[56+j] = 8'(bits >> (8*j));
    r = '0;
    for (int i = 0; i < 64; i++) r[511-8*i -: 8] = blk[i];
    return r;
  endfunction

  task automatic load_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask

  task automatic load_fill(input int n, input logic [7:0] b);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(b);
  endtask

  task automatic send(input bit gaps, input bit do_last);
    int t;
    for (int i = 0; i < msg.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_last  = 1'($urandom_range(1));
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = msg[i];
      in_last  = do_last && (i == msg.size() - 1);
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t == 50) begin
        checks++;
        errors++;
        $display("FAIL send_ready: in_ready stuck 0 expected 1");
      end
      @(posedge clk);
    end
  endtask

  task automatic wait_block(output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      if (mesg_valid) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      errors++;
      $display("FAIL mesg_valid_timeout: got none expected valid");
    end
    checks++;
  endtask

  task automatic finish_block(input string name);
    @(negedge clk);
    blocks++;
    chk({name, "_after"}, {mesg_valid, in_ready, (mesg == '0)},
        {1'b0, 1'b1, 1'b1});
  endtask

  task automatic run_good(input string name, input logic [511:0] exp,
                          input bit gaps);
    int lat;
    int e0;
    e0 = err_seen;
    send(gaps, 1'b1);
    wait_block(lat);
    chk({name, "_lat"}, 512'(lat), 512'd3);
    chk({name, "_mesg"}, mesg, exp);
    finish_block(name);
    chk({name, "_noerr"}, 512'(err_seen - e0), 512'd0);
  endtask

  task automatic run_bad(input string name, input bit gaps);
    int e0;
    bit saw;
    e0 = err_seen;
    saw = 1'b0;
    send(gaps, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      if (mesg_valid) saw = 1'b1;
    end
    chk({name, "_err"}, 512'(err_seen - e0), 512'd1);
    chk({name, "_nomv"}, 512'(saw), 512'd0);
  endtask

  initial begin
    int lat;
    int l;
    logic [511:0] exp;
    bit stable;
    bit rdy;

    vecs[0] = '{"The quick brown fox jumps over the lazy dog", 0, 8'h00,
      512'h54686520_71756963_6b206272_6f776e20_666f7820_6a756d70_73206f76_65722074_6865206c_617a7920_646f6780_00000000_00000000_00000000_58010000_00000000};
    vecs[1] = '{"abc", 0, 8'h00,
      {32'h61626380, 416'h0, 32'h18000000, 32'h0}};
    vecs[2] = '{"", 55, 8'h61,
      {{55{8'h61}}, 8'h80, 8'hB8, 8'h01, 48'h0}};
    vecs[3] = '{"a", 0, 8'h00,
      {8'h61, 8'h80, 432'h0, 8'h08, 56'h0}};

    reset = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b0;
    in_last = 1'b0;
    mesg_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", {mesg, mesg_valid, err, in_ready},
        {512'h0, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 512'(in_ready), 512'd1);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].n != 0) load_fill(vecs[i].n, vecs[i].fill);
      else load_str(vecs[i].txt);
      run_good($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
    end

    load_fill(56, 8'h61);
    run_bad("drop56", 1'b0);
    load_str("abc");
    run_good("abc_after_drop", vecs[1].exp, 1'b0);
    load_fill(60, 8'h62);
    run_bad("drop60", 1'b1);

    load_str("abc");
    mesg_ready = 1'b0;
    send(1'b0, 1'b1);
    wait_block(lat);
    exp = mesg;
    chk("bp_mesg", mesg, vecs[1].exp);
    stable = 1'b1;
    rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mesg !== exp || !mesg_valid) stable = 1'b0;
      if (in_ready) rdy = 1'b1;
    end
    chk("bp_hold", {stable, rdy}, {1'b1, 1'b0});
    mesg_ready = 1'b1;
    finish_block("bp");

    for (int r = 0; r < 24; r++) begin
      l = (r % 6 == 5) ? int'($urandom_range(60, 56))
                       : int'($urandom_range(55, 1));
      msg.delete();
      for (int i = 0; i < l; i++) msg.push_back(8'($urandom));
      if (l > 55) run_bad($sformatf("rnd%0d", r), 1'b1);
      else run_good($sformatf("rnd%0d", r), model(), 1'b1);
    end

`ifdef MD5_PADDER_CNT_EN
    chk("block_cnt", 512'(block_cnt), 512'(blocks));
`endif

    load_fill(10, 8'h41);
    send(1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_ready_low", 512'(in_ready), 512'd0);
    @(negedge clk);
    chk("midrst_state", {mesg, mesg_valid, err, in_ready},
        {512'h0, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mesg_valid) begin
        checks++;
        errors++;
        $display("FAIL midrst_mv: got 1 expected 0");
      end
    end
    load_str("abc");
    run_good("abc_after_rst", vecs[1].exp, 1'b0);
`ifdef MD5_PADDER_CNT_EN
    chk("block_cnt_rst", 512'(block_cnt), 512'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
